// File: rtl/fifo_stream_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain_pkg
// Purpose  : Shared constants and width helpers for the FIFO stream drain
//            (read-latency range, skid-buffer sizing rule, derived widths).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_stream_drain_pkg;

    // Supported FIFO read latency range.
    localparam int c_rd_lat_min = 1;
    localparam int c_rd_lat_max = 4;

    // The skid buffer must hold at least every word that can be in flight
    // plus the one sitting at the head while the stream is stalled.
    localparam int c_buf_slack_min = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Buffer pointer width, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Occupancy must be able to represent the value DEPTH itself.
    function automatic int occ_width(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    // Beat counter width, never narrower than one bit.
    function automatic int cnt_width(input int frame_len);
        return (clog2(frame_len) < 1) ? 1 : clog2(frame_len);
    endfunction

    // Width able to hold occupancy plus every in-flight read.
    function automatic int credit_width(input int depth, input int rd_lat);
        return clog2(depth + rd_lat + 1);
    endfunction

endpackage : fifo_stream_drain_pkg
`default_nettype wire

// File: rtl/fifo_stream_drain_skid_buf_ram.sv
`default_nettype none
// ============================================================================
// Module   : skid_buf_ram
// Purpose  : Circular DEPTH x D_WIDTH register buffer with push/pop pointers
//            and occupancy. Absorbs words returning from the FIFO read
//            pipeline while the stream is back-pressured.
// Ports    : i_clk, i_rst_n (sync, active-low)
//            i_push / i_push_data : write one word at the tail
//            i_pop                : retire the head word (ignored when empty)
//            o_head               : word at the head of the buffer
//            o_occ                : number of stored words (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module skid_buf_ram
    import fifo_stream_drain_pkg::*;
#(
    parameter int D_WIDTH = 48,
    parameter int DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [D_WIDTH-1:0]            i_push_data,
    input  logic                          i_pop,
    output logic [D_WIDTH-1:0]            o_head,
    output logic [occ_width(DEPTH)-1:0]   o_occ
);

    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_occ_w = occ_width(DEPTH);

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_occ_w-1:0] occ_q, occ_d;
    logic               w_pop_ok;
    logic               w_full;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_pop_ok = i_pop & (occ_q != '0);
    assign w_full   = (occ_q == c_occ_w'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (i_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({i_push, w_pop_ok})
            2'b10:   occ_d = occ_q + c_occ_w'(1);
            2'b01:   occ_d = occ_q - c_occ_w'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (i_push) begin
                mem_q[wr_ptr_q] <= i_push_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign o_head = mem_q[rd_ptr_q];
    assign o_occ  = occ_q;

`ifndef SYNTHESIS
    // The upstream credit check makes a push into a full buffer impossible.
    a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && w_full));
    a_occ_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        occ_q <= c_occ_w'(DEPTH));
`endif

endmodule : skid_buf_ram
`default_nettype wire

// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain
// Purpose  : Drains a synchronous FIFO read port (fixed read latency) into a
//            valid/ready stream. A credit-controlled skid buffer absorbs the
//            read latency so no word is lost under back-pressure; a beat
//            counter marks the last beat of each FRAME_LEN-beat frame.
// Ports    : i_clk, i_rst_n (sync, active-low)
//            i_en                      : allow new FIFO reads
//            i_fifo_empty/o_fifo_rd_en : FIFO read handshake
//            i_fifo_data               : read data, RD_LAT cycles after read
//            o_m_valid/i_m_ready/o_m_data/o_m_last : output stream
//            o_busy                    : reads in flight or words buffered
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int D_WIDTH   = 48,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_fifo_empty,
    output logic               o_fifo_rd_en,
    input  logic [D_WIDTH-1:0] i_fifo_data,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic [D_WIDTH-1:0] o_m_data,
    output logic               o_m_last,
    output logic               o_busy
);

    localparam int c_occ_w = occ_width(BUF_DEPTH);
    localparam int c_cnt_w = cnt_width(FRAME_LEN);
    localparam int c_crd_w = credit_width(BUF_DEPTH, RD_LAT);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(FRAME_LEN - 1);

    // Elaboration-time legality checks.
    if (RD_LAT < c_rd_lat_min || RD_LAT > c_rd_lat_max) begin : g_bad_rd_lat
        $error("fifo_stream_drain: RD_LAT outside supported range");
    end
    if (BUF_DEPTH < RD_LAT + c_buf_slack_min) begin : g_bad_buf_depth
        $error("fifo_stream_drain: BUF_DEPTH too small for RD_LAT");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("fifo_stream_drain: FRAME_LEN must be at least 1");
    end

    logic [RD_LAT-1:0]  inflight_q, inflight_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [c_crd_w-1:0] w_inflight_cnt;
    logic [c_crd_w-1:0] w_credit_used;
    logic [c_occ_w-1:0] w_occ;
    logic [D_WIDTH-1:0] w_head;
    logic               w_rd_en;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    // Number of reads issued whose data has not yet landed in the buffer.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + c_crd_w'(inflight_q[i]);
        end
    end

    // Credit check uses registered state only; this cycle's pop is not
    // credited back, which keeps the read-enable path short at the cost of
    // one slot of buffer slack.
    assign w_credit_used = c_crd_w'(w_occ) + w_inflight_cnt;
    assign w_rd_en       = i_en & ~i_fifo_empty & (w_credit_used < c_crd_w'(BUF_DEPTH));

    // Valid pipe: stage 0 is the newest read, stage RD_LAT-1 lands this cycle.
    if (RD_LAT == 1) begin : g_pipe_single
        assign inflight_d = w_rd_en;
    end else begin : g_pipe_multi
        assign inflight_d = {inflight_q[RD_LAT-2:0], w_rd_en};
    end

    assign w_push  = inflight_q[RD_LAT-1];
    assign w_valid = (w_occ != '0);
    assign w_pop   = w_valid & i_m_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (w_pop) begin
            cnt_d = (cnt_q == c_last_beat) ? '0 : cnt_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inflight_q <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    skid_buf_ram #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (BUF_DEPTH)
    ) u_skid_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (i_fifo_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign o_fifo_rd_en = w_rd_en;
    assign o_m_valid    = w_valid;
    assign o_m_data     = w_head;
    assign o_m_last     = w_valid & (cnt_q == c_last_beat);
    assign o_busy       = (|inflight_q) | w_valid;

endmodule : fifo_stream_drain
`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_drain
// Purpose  : Self-checking bench for fifo_stream_drain. Two instances:
//            A (RD_LAT=1, BUF_DEPTH=4) and B (RD_LAT=3, BUF_DEPTH=5), each fed
//            by a behavioural FIFO read-port model. Expected words are queued
//            when loaded into the FIFO model and popped on each stream beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_drain;

    localparam int c_dw      = 48;
    localparam int c_lat_a   = 1;
    localparam int c_depth_a = 4;
    localparam int c_lat_b   = 3;
    localparam int c_depth_b = 5;
    localparam int c_frame   = 16;
    localparam int c_src_max = 4096;
    localparam logic [c_dw-1:0] c_junk = 48'hBADB_ADBA_DBAD;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic m_ready;

    logic            a_fifo_empty, a_rd_en, a_m_valid, a_m_last, a_busy;
    logic [c_dw-1:0] a_fifo_data, a_m_data;
    logic            b_fifo_empty, b_rd_en, b_m_valid, b_m_last, b_busy;
    logic [c_dw-1:0] b_fifo_data, b_m_data;

    always #5 clk = ~clk;

    fifo_stream_drain #(
        .D_WIDTH(c_dw), .RD_LAT(c_lat_a), .BUF_DEPTH(c_depth_a), .FRAME_LEN(c_frame)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fifo_empty(a_fifo_empty),
        .o_fifo_rd_en(a_rd_en), .i_fifo_data(a_fifo_data), .o_m_valid(a_m_valid),
        .i_m_ready(m_ready), .o_m_data(a_m_data), .o_m_last(a_m_last), .o_busy(a_busy)
    );

    fifo_stream_drain #(
        .D_WIDTH(c_dw), .RD_LAT(c_lat_b), .BUF_DEPTH(c_depth_b), .FRAME_LEN(c_frame)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fifo_empty(b_fifo_empty),
        .o_fifo_rd_en(b_rd_en), .i_fifo_data(b_fifo_data), .o_m_valid(b_m_valid),
        .i_m_ready(m_ready), .o_m_data(b_m_data), .o_m_last(b_m_last), .o_busy(b_busy)
    );

    // ---------------- FIFO read-port models ----------------
    logic [c_dw-1:0] src_a [c_src_max];
    logic [c_dw-1:0] src_b [c_src_max];
    int              n_a = 0, n_b = 0;       // words loaded (bench side)
    int              idx_a = 0, idx_b = 0;   // words read (model side)
    logic            gap_mode = 1'b0;
    logic            gap_a = 1'b0, gap_b = 1'b0;
    logic [c_dw-1:0] lat_a = c_junk;
    logic [c_dw-1:0] lat_b [3];

    always @(posedge clk) begin
        lat_a    <= a_rd_en ? src_a[idx_a] : c_junk;
        lat_b[0] <= b_rd_en ? src_b[idx_b] : c_junk;
        lat_b[1] <= lat_b[0];
        lat_b[2] <= lat_b[1];
        if (a_rd_en) idx_a <= idx_a + 1;
        if (b_rd_en) idx_b <= idx_b + 1;
        gap_a <= gap_mode && ($urandom_range(0, 99) < 25);
        gap_b <= gap_mode && ($urandom_range(0, 99) < 25);
    end

    assign a_fifo_empty = gap_a || (idx_a >= n_a);
    assign b_fifo_empty = gap_b || (idx_b >= n_b);
    assign a_fifo_data  = lat_a;
    assign b_fifo_data  = lat_b[2];

    // ---------------- scoreboard ----------------
    logic [c_dw-1:0] exp_a [$];
    logic [c_dw-1:0] exp_b [$];
    int beat_a = 0, beat_b = 0;
    int n_vec = 0, n_bad = 0;

    task automatic add_a(input logic [c_dw-1:0] w);
        src_a[n_a] = w; n_a++; exp_a.push_back(w);
    endtask

    task automatic add_b(input logic [c_dw-1:0] w);
        src_b[n_b] = w; n_b++; exp_b.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if ({a_m_valid, a_m_last, a_busy, a_rd_en} !== 4'b0) begin
            n_bad++; $display("FAIL reset_a_flags: got %b expected 0000", {a_m_valid, a_m_last, a_busy, a_rd_en}); end
        n_vec++; if (a_m_data !== '0) begin
            n_bad++; $display("FAIL reset_a_data: got %h expected 0", a_m_data); end
        n_vec++; if ({b_m_valid, b_m_last, b_busy, b_rd_en} !== 4'b0) begin
            n_bad++; $display("FAIL reset_b_flags: got %b expected 0000", {b_m_valid, b_m_last, b_busy, b_rd_en}); end
        n_vec++; if (b_m_data !== '0) begin
            n_bad++; $display("FAIL reset_b_data: got %h expected 0", b_m_data); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [c_dw-1:0] w;
        en = 1'b0; m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) add_a(48'(i));
        tick();
        en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++; if (a_rd_en !== (c < 5)) begin
                n_bad++; $display("FAIL basic_rd_en c%0d: got %b expected %b", c, a_rd_en, (c < 5)); end
            n_vec++; if (a_m_valid !== (c >= 2 && c <= 6)) begin
                n_bad++; $display("FAIL basic_valid c%0d: got %b expected %b", c, a_m_valid, (c >= 2 && c <= 6)); end
            n_vec++; if (a_busy !== (c >= 1 && c <= 6)) begin
                n_bad++; $display("FAIL basic_busy c%0d: got %b expected %b", c, a_busy, (c >= 1 && c <= 6)); end
            if (a_m_valid && m_ready) begin
                n_vec++;
                if (exp_a.size() == 0) begin
                    n_bad++; $display("FAIL basic_extra_beat: got %h expected none", a_m_data);
                end else begin
                    w = exp_a.pop_front();
                    if (a_m_data !== w || a_m_last !== ((beat_a % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL basic_beat%0d: got %h/%b expected %h/%b", beat_a, a_m_data, a_m_last, w, ((beat_a % c_frame) == c_frame - 1)); end
                    beat_a++;
                end
            end
            tick();
        end
    endtask

    task automatic test_throughput();
        logic [c_dw-1:0] w;
        int got, first_c, last_c;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        beat_a = 0; beat_b = 0;
        en = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 48; i++) add_a({16'(i + 16'h100), 32'($urandom)});
        tick();
        en = 1'b1;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 200 && got < 48; c++) begin
            @(negedge clk);
            if (a_m_valid && m_ready) begin
                n_vec++;
                if (first_c < 0) first_c = c;
                last_c = c; got++;
                if (exp_a.size() == 0) begin
                    n_bad++; $display("FAIL tput_extra_beat: got %h expected none", a_m_data);
                end else begin
                    w = exp_a.pop_front();
                    if (a_m_data !== w || a_m_last !== ((beat_a % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL tput_beat%0d: got %h/%b expected %h/%b", beat_a, a_m_data, a_m_last, w, ((beat_a % c_frame) == c_frame - 1)); end
                    beat_a++;
                end
            end
            tick();
        end
        n_vec++; if (got != 48 || last_c - first_c != 47) begin
            n_bad++; $display("FAIL tput_rate: got %0d beats over %0d cycles expected 48 over 48", got, last_c - first_c + 1); end
    endtask

    task automatic test_backpressure();
        logic [c_dw-1:0] w, held_d;
        logic held_l;
        held_d = '0; held_l = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 30; i++) add_a({16'(i + 16'h200), 32'($urandom)});
        for (int c = 0; c < 300; c++) begin
            m_ready = !(c >= 10 && c <= 19);
            @(negedge clk);
            if (c == 10) begin
                held_d = a_m_data; held_l = a_m_last;
                n_vec++; if (a_m_valid !== 1'b1) begin
                    n_bad++; $display("FAIL bp_valid_at_stall: got %b expected 1", a_m_valid); end
            end
            if (c > 10 && c <= 19) begin
                n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== held_d || a_m_last !== held_l) begin
                    n_bad++; $display("FAIL bp_hold c%0d: got %b/%h/%b expected 1/%h/%b", c, a_m_valid, a_m_data, a_m_last, held_d, held_l); end
            end
            if (c >= 14 && c <= 19) begin
                n_vec++; if (a_rd_en !== 1'b0) begin
                    n_bad++; $display("FAIL bp_rd_en c%0d: got %b expected 0", c, a_rd_en); end
            end
            if (a_m_valid && m_ready) begin
                n_vec++;
                if (exp_a.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra_beat: got %h expected none", a_m_data);
                end else begin
                    w = exp_a.pop_front();
                    if (a_m_data !== w || a_m_last !== ((beat_a % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", beat_a, a_m_data, a_m_last, w, ((beat_a % c_frame) == c_frame - 1)); end
                    beat_a++;
                end
            end
            tick();
            if (c > 20 && exp_a.size() == 0) break;
        end
        m_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (exp_a.size() != 0 || a_busy !== 1'b0 || a_m_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_drain: got %0d left busy %b valid %b expected 0 0 0", exp_a.size(), a_busy, a_m_valid); end
        tick();
    endtask

    task automatic test_en_drop();
        logic [c_dw-1:0] w;
        int got;
        en = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) add_b({16'(i + 16'h300), 32'($urandom)});
        tick();
        got = 0;
        for (int c = 0; c < 10; c++) begin
            en = (c < 2);
            @(negedge clk);
            n_vec++; if (b_rd_en !== (c < 2)) begin
                n_bad++; $display("FAIL endrop_rd_en c%0d: got %b expected %b", c, b_rd_en, (c < 2)); end
            n_vec++; if (b_busy !== (c >= 1 && c <= 5)) begin
                n_bad++; $display("FAIL endrop_busy c%0d: got %b expected %b", c, b_busy, (c >= 1 && c <= 5)); end
            n_vec++; if (b_m_valid !== (c == 4 || c == 5)) begin
                n_bad++; $display("FAIL endrop_valid c%0d: got %b expected %b", c, b_m_valid, (c == 4 || c == 5)); end
            if (b_m_valid && m_ready) begin
                n_vec++; got++;
                if (exp_b.size() == 0) begin
                    n_bad++; $display("FAIL endrop_extra_beat: got %h expected none", b_m_data);
                end else begin
                    w = exp_b.pop_front();
                    if (b_m_data !== w || b_m_last !== ((beat_b % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL endrop_beat%0d: got %h/%b expected %h/%b", beat_b, b_m_data, b_m_last, w, ((beat_b % c_frame) == c_frame - 1)); end
                    beat_b++;
                end
            end
            tick();
        end
        n_vec++; if (got != 2) begin
            n_bad++; $display("FAIL endrop_count: got %0d expected 2", got); end
    endtask

    task automatic test_random();
        logic [c_dw-1:0] w;
        int cyc;
        en = 1'b1; gap_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            add_a({16'(i + 16'h1000), 32'($urandom)});
            add_b({16'(i + 16'h5000), 32'($urandom)});
        end
        cyc = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && cyc < 20000) begin
            m_ready = ($urandom_range(0, 99) >= 30);
            @(negedge clk);
            if (a_m_valid && m_ready) begin
                n_vec++;
                if (exp_a.size() == 0) begin
                    n_bad++; $display("FAIL rand_a_extra_beat: got %h expected none", a_m_data);
                end else begin
                    w = exp_a.pop_front();
                    if (a_m_data !== w || a_m_last !== ((beat_a % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL rand_a_beat%0d: got %h/%b expected %h/%b", beat_a, a_m_data, a_m_last, w, ((beat_a % c_frame) == c_frame - 1)); end
                    beat_a++;
                end
            end
            if (b_m_valid && m_ready) begin
                n_vec++;
                if (exp_b.size() == 0) begin
                    n_bad++; $display("FAIL rand_b_extra_beat: got %h expected none", b_m_data);
                end else begin
                    w = exp_b.pop_front();
                    if (b_m_data !== w || b_m_last !== ((beat_b % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL rand_b_beat%0d: got %h/%b expected %h/%b", beat_b, b_m_data, b_m_last, w, ((beat_b % c_frame) == c_frame - 1)); end
                    beat_b++;
                end
            end
            tick();
            cyc++;
        end
        n_vec++; if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_bad++; $display("FAIL rand_timeout: got %0d/%0d words left expected 0/0", exp_a.size(), exp_b.size()); end
        gap_mode = 1'b0; m_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic [c_dw-1:0] w;
        int got;
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) add_a({16'(i + 16'h700), 32'($urandom)});
        repeat (6) tick();
        @(negedge clk);
        w = exp_a[0];
        n_vec++; if (a_m_valid !== 1'b1 || a_m_data !== w) begin
            n_bad++; $display("FAIL rstmid_pre: got %b/%h expected 1/%h", a_m_valid, a_m_data, w); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_a.delete(); exp_b.delete();
        beat_a = 0; beat_b = 0;
        @(negedge clk);
        n_vec++; if ({a_m_valid, a_busy, a_m_last, a_rd_en} !== 4'b0) begin
            n_bad++; $display("FAIL rstmid_flags: got %b expected 0000", {a_m_valid, a_busy, a_m_last, a_rd_en}); end
        n_vec++; if (a_m_data !== '0) begin
            n_bad++; $display("FAIL rstmid_data: got %h expected 0", a_m_data); end
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) add_a({16'(i + 16'h800), 32'($urandom)});
        got = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            @(negedge clk);
            if (a_m_valid && m_ready) begin
                n_vec++; got++;
                if (exp_a.size() == 0) begin
                    n_bad++; $display("FAIL rstmid_extra_beat: got %h expected none", a_m_data);
                end else begin
                    w = exp_a.pop_front();
                    if (a_m_data !== w || a_m_last !== ((beat_a % c_frame) == c_frame - 1)) begin
                        n_bad++; $display("FAIL rstmid_beat%0d: got %h/%b expected %h/%b", beat_a, a_m_data, a_m_last, w, ((beat_a % c_frame) == c_frame - 1)); end
                    beat_a++;
                end
            end
            tick();
        end
        n_vec++; if (got != 16) begin
            n_bad++; $display("FAIL rstmid_count: got %0d expected 16", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throughput();
        test_backpressure();
        test_en_drop();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_stream_drain
`default_nettype wire
